// File: rtl/count_mon_pkg.sv
// count_mon_pkg
// Shared types for the count window monitor: zone encoding, the event record
// layout and its width.
package count_mon_pkg;

    localparam int CNT_W = 8;
    localparam int EVT_W = CNT_W + 4;

    typedef enum logic [1:0] {
        BELOW  = 2'd0,
        INSIDE = 2'd1,
        ABOVE  = 2'd2
    } zone_t;

    typedef struct packed {
        logic             wrap_up;
        logic             wrap_dn;
        zone_t            zone;
        logic [CNT_W-1:0] value;
    } evt_t;

endpackage

// File: rtl/count_window_monitor_evt_fifo.sv
// evt_fifo
// Synchronous FIFO holding event records between the monitor and its consumer.
// A push into a full FIFO is accepted only if the head is popped in the same
// cycle; otherwise it is reported on overflow. There is no empty bypass, so a
// record written into an empty FIFO becomes visible one cycle later.
// Ports:
//   clk, clear       clock, asynchronous active-high clear
//   push, wdata      write request and record
//   ready            consumer accepts the head
//   valid, rdata     head present / head record
//   overflow         combinational: this cycle's push is being lost
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] rdata,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         empty;
    logic         full;
    logic         pop;
    logic         wr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = !empty && ready;
    assign wr       = push && (!full || pop);
    assign overflow = push && full && !pop;
    assign valid    = !empty;
    assign rdata    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/count_window_monitor.sv
// count_window_monitor
// Watches the up/down counter output, classifies it against programmable
// low/high thresholds with hysteresis, flags wrap-around and queues one event
// record per change for a valid/ready consumer.
// Ports:
//   clk, clear            clock, asynchronous active-high reset
//   qd                    monitored count
//   lo_thr, hi_thr        candidate thresholds, latched on cfg_load
//   cfg_load / cfg_err    load request / one-cycle reject pulse (lo_thr > hi_thr)
//   zone                  current zone (0 BELOW, 1 INSIDE, 2 ABOVE)
//   evt_valid/ready/data  event stream {wrap_up, wrap_dn, zone, value}
//   evt_drop / drop_clr   sticky overflow flag / its clear
//
// Zone state machine:
//   state  | meaning
//   BELOW  | count below lo; leaves to INSIDE only at lo+HYST or more
//   INSIDE | count within [lo, hi]
//   ABOVE  | count above hi; leaves to INSIDE only at hi-HYST or less
module count_window_monitor
    import count_mon_pkg::*;
#(
    parameter int               WIDTH  = CNT_W,
    parameter int               HYST   = 2,
    parameter int               DEPTH  = 4,
    parameter logic [WIDTH-1:0] LO_RST = 8'h10,
    parameter logic [WIDTH-1:0] HI_RST = 8'hF0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] qd,
    input  logic [WIDTH-1:0] lo_thr,
    input  logic [WIDTH-1:0] hi_thr,
    input  logic             cfg_load,
    output logic             cfg_err,
    output logic [1:0]       zone,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH+3:0] evt_data,
    output logic             evt_drop,
    input  logic             drop_clr
);

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             samp;
    logic             primed;
    logic             reprime;
    zone_t            zone_q;
    zone_t            zone_d;
    logic             cfg_ok;
    logic [WIDTH:0]   lo_up;
    logic [WIDTH:0]   hi_dn;
    logic [WIDTH-1:0] lo_exit;
    logic [WIDTH-1:0] hi_exit;
    logic             wrap_up;
    logic             wrap_dn;
    logic             evt_push;
    logic [WIDTH+3:0] evt_rec;
    logic             overflow;

    assign cfg_ok = cfg_load && (lo_thr <= hi_thr);

    // Hysteresis exit points, computed one bit wider and clamped to the range.
    assign lo_up   = {1'b0, lo} + (WIDTH+1)'(HYST);
    assign hi_dn   = {1'b0, hi} - (WIDTH+1)'(HYST);
    assign lo_exit = lo_up[WIDTH] ? '1 : lo_up[WIDTH-1:0];
    assign hi_exit = hi_dn[WIDTH] ? '0 : hi_dn[WIDTH-1:0];

    assign wrap_up = primed && (prev == '1) && (cur == '0);
    assign wrap_dn = primed && (prev == '0) && (cur == '1);

    // samp: cur holds a real sample rather than its reset value.
    always_comb begin
        zone_d = zone_q;
        if (samp) begin
            if (!primed) begin
                if (cur < lo) begin
                    zone_d = BELOW;
                end else if (cur > hi) begin
                    zone_d = ABOVE;
                end else begin
                    zone_d = INSIDE;
                end
            end else begin
                case (zone_q)
                    BELOW: begin
                        if (cur > hi) begin
                            zone_d = ABOVE;
                        end else if (cur >= lo_exit) begin
                            zone_d = INSIDE;
                        end
                    end
                    ABOVE: begin
                        if (cur < lo) begin
                            zone_d = BELOW;
                        end else if (cur <= hi_exit) begin
                            zone_d = INSIDE;
                        end
                    end
                    default: begin
                        if (cur < lo) begin
                            zone_d = BELOW;
                        end else if (cur > hi) begin
                            zone_d = ABOVE;
                        end else begin
                            zone_d = INSIDE;
                        end
                    end
                endcase
            end
        end
    end

    // The unprimed evaluation after reset is silent; after a threshold reload
    // it reports a zone change caused by the new thresholds.
    always_comb begin
        evt_push = 1'b0;
        if (samp) begin
            if (primed) begin
                evt_push = (zone_d != zone_q) || wrap_up || wrap_dn;
            end else begin
                evt_push = reprime && (zone_d != zone_q);
            end
        end
    end

    assign evt_rec = {wrap_up, wrap_dn, zone_d, cur};

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cur     <= '0;
            prev    <= '0;
            samp    <= 1'b0;
            primed  <= 1'b0;
            reprime <= 1'b0;
            zone_q  <= INSIDE;
            lo      <= LO_RST;
            hi      <= HI_RST;
            cfg_err <= 1'b0;
        end else begin
            cur     <= qd;
            prev    <= cur;
            samp    <= 1'b1;
            zone_q  <= zone_d;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                lo      <= lo_thr;
                hi      <= hi_thr;
                primed  <= 1'b0;
                reprime <= 1'b1;
            end else begin
                primed <= samp;
                if (samp && !primed) begin
                    reprime <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            evt_drop <= 1'b0;
        end else if (overflow) begin
            evt_drop <= 1'b1;
        end else if (drop_clr) begin
            evt_drop <= 1'b0;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .W     (WIDTH + 4)
    ) u_fifo (
        .clk      (clk),
        .clear    (clear),
        .push     (evt_push),
        .wdata    (evt_rec),
        .ready    (evt_ready),
        .valid    (evt_valid),
        .rdata    (evt_data),
        .overflow (overflow)
    );

    assign zone = zone_q;

endmodule

// File: tb/tb_count_window_monitor.sv
module tb_count_window_monitor;
    import count_mon_pkg::*;

    logic        clk;
    logic        clear;
    logic [7:0]  qd;
    logic [7:0]  lo_thr;
    logic [7:0]  hi_thr;
    logic        cfg_load;
    logic        cfg_err;
    logic [1:0]  zone;
    logic        evt_valid;
    logic        evt_ready;
    logic [11:0] evt_data;
    logic        evt_drop;
    logic        drop_clr;

    count_window_monitor dut (
        .clk       (clk),
        .clear     (clear),
        .qd        (qd),
        .lo_thr    (lo_thr),
        .hi_thr    (hi_thr),
        .cfg_load  (cfg_load),
        .cfg_err   (cfg_err),
        .zone      (zone),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_drop  (evt_drop),
        .drop_clr  (drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  qd;
        zone_t       zone;
        logic        evt;
        logic [11:0] data;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          n_cmp;
    int          n_bad;

    function automatic logic [11:0] rec(logic wu, logic wd, zone_t z, logic [7:0] v);
        evt_t e;
        e.wrap_up = wu;
        e.wrap_dn = wd;
        e.zone    = z;
        e.value   = v;
        return e;
    endfunction

    function automatic void add(logic [7:0] q, zone_t z, logic e, logic [11:0] d);
        vec_t v;
        v.qd   = q;
        v.zone = z;
        v.evt  = e;
        v.data = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply qd and hold it for two edges: the first edge samples it, the
    // second pushes any resulting record.
    task automatic hold2(input logic [7:0] v);
        qd = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        clear     = 1'b1;
        qd        = 8'h00;
        lo_thr    = 8'h00;
        hi_thr    = 8'h00;
        cfg_load  = 1'b0;
        evt_ready = 1'b1;
        drop_clr  = 1'b0;

        // Ramp up from reset, up through ABOVE and back, then wrap both ways.
        for (int v = 0; v <= 8'h11; v++) add(8'(v), BELOW, 1'b0, 12'h0);
        add(8'h12, INSIDE, 1'b1, rec(1'b0, 1'b0, INSIDE, 8'h12));
        for (int v = 8'h13; v <= 8'hF0; v++) add(8'(v), INSIDE, 1'b0, 12'h0);
        add(8'hF1, ABOVE,  1'b1, rec(1'b0, 1'b0, ABOVE, 8'hF1));
        add(8'hF0, ABOVE,  1'b0, 12'h0);
        add(8'hEF, ABOVE,  1'b0, 12'h0);
        add(8'hEE, INSIDE, 1'b1, rec(1'b0, 1'b0, INSIDE, 8'hEE));
        add(8'hFF, ABOVE,  1'b1, rec(1'b0, 1'b0, ABOVE, 8'hFF));
        add(8'h00, BELOW,  1'b1, rec(1'b1, 1'b0, BELOW, 8'h00));
        add(8'h00, BELOW,  1'b0, 12'h0);
        add(8'hFF, ABOVE,  1'b1, rec(1'b0, 1'b1, ABOVE, 8'hFF));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_zone", 32'(zone), 32'(INSIDE));
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_drop", 32'(evt_drop), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        clear = 1'b0;

        foreach (vecs[i]) begin
            hold2(vecs[i].qd);
            check($sformatf("vec%0d_zone", i), 32'(zone), 32'(vecs[i].zone));
            check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].evt));
            if (vecs[i].evt) begin
                check($sformatf("vec%0d_data", i), 32'(evt_data), 32'(vecs[i].data));
            end
        end

        // Overflow: consumer stalled across five events.
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        exp_q.push_back(rec(1'b0, 1'b0, INSIDE, 8'h80));
        exp_q.push_back(rec(1'b0, 1'b0, BELOW,  8'h00));
        exp_q.push_back(rec(1'b0, 1'b0, INSIDE, 8'h80));
        exp_q.push_back(rec(1'b0, 1'b0, ABOVE,  8'hFF));
        hold2(8'h80);
        hold2(8'h00);
        hold2(8'h80);
        hold2(8'hFF);
        check("pre_drop", 32'(evt_drop), 32'd0);
        hold2(8'h80);
        check("drop_set", 32'(evt_drop), 32'd1);
        check("stall_valid", 32'(evt_valid), 32'd1);
        check("stall_head", 32'(evt_data), 32'(exp_q[0]));
        drop_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_clr = 1'b0;
        check("drop_clr", 32'(evt_drop), 32'd0);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(evt_valid), 32'd1);
            check($sformatf("drain%0d_data", k), 32'(evt_data), 32'(exp_q[k]));
            @(posedge clk);
            @(negedge clk);
        end
        check("drain_empty", 32'(evt_valid), 32'd0);

        // Rejected load leaves the default thresholds in place.
        lo_thr   = 8'h80;
        hi_thr   = 8'h40;
        cfg_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        hold2(8'h90);
        check("rej_zone", 32'(zone), 32'(INSIDE));
        check("rej_no_evt", 32'(evt_valid), 32'd0);

        // Accepted load re-primes and reports the new zone.
        lo_thr   = 8'h40;
        hi_thr   = 8'h80;
        cfg_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
        check("cfg_ok_no_err", 32'(cfg_err), 32'd0);
        begin
            bit found;
            found = 1'b0;
            for (int t = 0; t < 6 && !found; t++) begin
                if (evt_valid) begin
                    found = 1'b1;
                    check("reprime_data", 32'(evt_data), 32'(rec(1'b0, 1'b0, ABOVE, 8'h90)));
                end else begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            check("reprime_seen", 32'(found), 32'd1);
        end
        check("reprime_zone", 32'(zone), 32'(ABOVE));
        @(posedge clk);
        @(negedge clk);

        // Reset with queued events while the consumer toggles ready.
        evt_ready = 1'b0;
        hold2(8'h20);
        hold2(8'h60);
        hold2(8'h90);
        check("q3_valid", 32'(evt_valid), 32'd1);
        check("q3_head", 32'(evt_data), 32'(rec(1'b0, 1'b0, BELOW, 8'h20)));
        evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b1;
        #1;
        check("clr_valid_async", 32'(evt_valid), 32'd0);
        check("clr_zone_async", 32'(zone), 32'(INSIDE));
        @(negedge clk);
        clear = 1'b0;
        check("post_clr_drop", 32'(evt_drop), 32'd0);
        check("post_clr_zone", 32'(zone), 32'(INSIDE));
        hold2(8'h90);
        check("post_clr_first_zone", 32'(zone), 32'(INSIDE));
        check("post_clr_no_evt", 32'(evt_valid), 32'd0);
        hold2(8'h90);
        check("post_clr_still_empty", 32'(evt_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
